serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 114 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial N-bit subtractor (A - B - Bin), LSB first, one bit
//                per clock. Optional signed-overflow flag V is built when the
//                macro SERIAL_SUB_OVERFLOW_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int N = 4
) (
    input  logic         Clock,
    input  logic         Reset_b,
    input  logic         Start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic [N-1:0] Diff,
    output logic         Borrow,
    output logic         Busy,
    output logic         Done
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic         V
`endif
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic          br;
    logic [CW-1:0] cnt;

    logic          d_bit;
    logic          br_next;
    logic          last_bit;

    // One full-subtractor slice on the current LSBs and the running borrow
    always_comb begin
        d_bit    = a_sh[0] ^ b_sh[0] ^ br;
        br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        last_bit = (cnt == CW'(N - 1));
    end

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state  <= S_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            Diff   <= '0;
            Borrow <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            V      <= 1'b0;
`endif
        end else begin
            // Done trails the DONE state by one edge so it lines up with the
            // cycle in which the next operation (if any) has just been loaded.
            Done <= (state == S_DONE);

            case (state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        br    <= Bin;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        state <= S_SHIFT;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    Diff <= {d_bit, Diff[N-1:1]};
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        Borrow <= br_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        // Borrow into the MSB differs from borrow out of it
                        V      <= br ^ br_next;
`endif
                        Busy   <= 1'b0;
                        state  <= S_DONE;
                    end
                end

                default: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
